// File: rtl/eth_measurer_pkg.sv
// Shared types and constants for the Ethernet ping/pong latency measurer.
package eth_measurer_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        DELAY     = 3'd1,
        PING_TX   = 3'd2,
        WAIT_PING = 3'd3,
        PONG_TX   = 3'd4,
        WAIT_PONG = 3'd5
    } state_t;

    localparam logic [31:0] TIME_LOST = 32'hFFFF_FFFF;

    // Elapsed time clipped to 32 bits; anything that does not fit reads as "lost".
    function automatic logic [31:0] sat_elapsed(input logic [63:0] now, input logic [63:0] start);
        logic [63:0] diff;
        diff = now - start;
        return (diff[63:32] != 32'd0) ? TIME_LOST : diff[31:0];
    endfunction

endpackage

// File: rtl/eth_measurer_core.sv
// Ping/pong round-trip measurer: sends a ping on the main port, times its arrival on
// the loop port, answers with a pong, and times the pong back to the main port.
module eth_measurer_core
    import eth_measurer_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        srst,
    input  logic [31:0] delay,
    input  logic [31:0] timeout,
    input  logic [63:0] current_time,
    output logic        ping_start,
    output logic [31:0] ping_id,
    input  logic        ping_tx_done,
    input  logic        pong_rx_valid,
    input  logic [31:0] pong_rx_id,
    output logic        pong_start,
    input  logic        ping_rx_valid,
    input  logic [31:0] ping_rx_id,
    input  logic        pong_tx_done,
    output logic        ping_pong_done,
    output logic [31:0] ping_time,
    output logic [31:0] pong_time,
    output logic [63:0] ping_pongs_good,
    output logic [63:0] pings_lost,
    output logic [63:0] pongs_lost,
    output logic [2:0]  state
);

    state_t      fsm;
    logic [31:0] timer;
    logic [63:0] t_tx;
    logic [31:0] timer_inc;

    assign state     = fsm;
    assign timer_inc = (&timer) ? timer : timer + 32'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm             <= IDLE;
            timer           <= '0;
            t_tx            <= '0;
            ping_id         <= '0;
            ping_start      <= 1'b0;
            pong_start      <= 1'b0;
            ping_pong_done  <= 1'b0;
            ping_time       <= '0;
            pong_time       <= '0;
            ping_pongs_good <= '0;
            pings_lost      <= '0;
            pongs_lost      <= '0;
        end else if (srst) begin
            fsm             <= IDLE;
            timer           <= '0;
            t_tx            <= '0;
            ping_id         <= '0;
            ping_start      <= 1'b0;
            pong_start      <= 1'b0;
            ping_pong_done  <= 1'b0;
            ping_time       <= '0;
            pong_time       <= '0;
            ping_pongs_good <= '0;
            pings_lost      <= '0;
            pongs_lost      <= '0;
        end else begin
            ping_start     <= 1'b0;
            pong_start     <= 1'b0;
            ping_pong_done <= 1'b0;
            case (fsm)
                IDLE: begin
                    if (enable) begin
                        fsm   <= DELAY;
                        timer <= '0;
                    end
                end
                DELAY: begin
                    if (!enable) begin
                        fsm <= IDLE;
                    end else if (timer >= delay) begin
                        fsm        <= PING_TX;
                        ping_start <= 1'b1;
                        ping_id    <= ping_id + 32'd1;
                    end else begin
                        timer <= timer_inc;
                    end
                end
                PING_TX: begin
                    if (ping_tx_done) begin
                        t_tx  <= current_time;
                        timer <= '0;
                        fsm   <= WAIT_PING;
                    end
                end
                WAIT_PING: begin
                    // A matching ping wins over a timeout landing on the same cycle.
                    if (ping_rx_valid && ping_rx_id == ping_id) begin
                        ping_time  <= sat_elapsed(current_time, t_tx);
                        pong_start <= 1'b1;
                        fsm        <= PONG_TX;
                    end else if (timer >= timeout) begin
                        pings_lost     <= pings_lost + 64'd1;
                        ping_time      <= TIME_LOST;
                        pong_time      <= TIME_LOST;
                        ping_pong_done <= 1'b1;
                        timer          <= '0;
                        fsm            <= enable ? DELAY : IDLE;
                    end else begin
                        timer <= timer_inc;
                    end
                end
                PONG_TX: begin
                    if (pong_tx_done) begin
                        t_tx  <= current_time;
                        timer <= '0;
                        fsm   <= WAIT_PONG;
                    end
                end
                WAIT_PONG: begin
                    if (pong_rx_valid && pong_rx_id == ping_id) begin
                        pong_time       <= sat_elapsed(current_time, t_tx);
                        ping_pongs_good <= ping_pongs_good + 64'd1;
                        ping_pong_done  <= 1'b1;
                        timer           <= '0;
                        fsm             <= enable ? DELAY : IDLE;
                    end else if (timer >= timeout) begin
                        pongs_lost     <= pongs_lost + 64'd1;
                        pong_time      <= TIME_LOST;
                        ping_pong_done <= 1'b1;
                        timer          <= '0;
                        fsm            <= enable ? DELAY : IDLE;
                    end else begin
                        timer <= timer_inc;
                    end
                end
                default: fsm <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_eth_measurer_core.sv
// Directed bench for eth_measurer_core: good exchange, ping loss, pong loss,
// match-at-timeout, enable drop and soft reset mid-exchange.
module tb_eth_measurer_core;
    import eth_measurer_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n, enable, srst;
    logic [31:0] delay, timeout;
    logic [63:0] current_time;
    logic        ping_start, pong_start, ping_pong_done;
    logic [31:0] ping_id, ping_time, pong_time;
    logic        ping_tx_done, pong_rx_valid, ping_rx_valid, pong_tx_done;
    logic [31:0] pong_rx_id, ping_rx_id;
    logic [63:0] ping_pongs_good, pings_lost, pongs_lost;
    logic [2:0]  state;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    eth_measurer_core dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .srst(srst),
        .delay(delay), .timeout(timeout), .current_time(current_time),
        .ping_start(ping_start), .ping_id(ping_id), .ping_tx_done(ping_tx_done),
        .pong_rx_valid(pong_rx_valid), .pong_rx_id(pong_rx_id),
        .pong_start(pong_start), .ping_rx_valid(ping_rx_valid), .ping_rx_id(ping_rx_id),
        .pong_tx_done(pong_tx_done), .ping_pong_done(ping_pong_done),
        .ping_time(ping_time), .pong_time(pong_time),
        .ping_pongs_good(ping_pongs_good), .pings_lost(pings_lost),
        .pongs_lost(pongs_lost), .state(state)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic soft_reset();
        enable = 1'b0;
        srst   = 1'b1;
        step();
        srst   = 1'b0;
    endtask

    task automatic wait_ping_start(input int budget, output int cycles);
        cycles = -1;
        for (int i = 1; i <= budget; i++) begin
            step();
            if (ping_start) begin
                cycles = i;
                break;
            end
        end
    endtask

    task automatic wait_done(input int budget, output int cycles, output logic pong_seen);
        cycles    = -1;
        pong_seen = 1'b0;
        for (int i = 1; i <= budget; i++) begin
            step();
            if (pong_start) pong_seen = 1'b1;
            if (ping_pong_done) begin
                cycles = i;
                break;
            end
        end
    endtask

    task automatic pulse_ping_tx(input logic [63:0] t);
        ping_tx_done = 1'b1; current_time = t; step(); ping_tx_done = 1'b0;
    endtask

    task automatic pulse_ping_rx(input logic [31:0] id, input logic [63:0] t);
        ping_rx_valid = 1'b1; ping_rx_id = id; current_time = t; step(); ping_rx_valid = 1'b0;
    endtask

    task automatic pulse_pong_tx(input logic [63:0] t);
        pong_tx_done = 1'b1; current_time = t; step(); pong_tx_done = 1'b0;
    endtask

    task automatic pulse_pong_rx(input logic [31:0] id, input logic [63:0] t);
        pong_rx_valid = 1'b1; pong_rx_id = id; current_time = t; step(); pong_rx_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b0; srst = 1'b0; delay = '0; timeout = '0; current_time = '0;
        ping_tx_done = 1'b0; pong_rx_valid = 1'b0; pong_rx_id = '0;
        ping_rx_valid = 1'b0; ping_rx_id = '0; pong_tx_done = 1'b0;
        step(); step();
        checks++; if (state !== 3'(IDLE)) begin errors++; $display("FAIL reset_state got %0d exp %0d", state, IDLE); end
        checks++; if ({ping_start, pong_start, ping_pong_done} !== 3'b000) begin errors++; $display("FAIL reset_strobes got %b exp 000", {ping_start, pong_start, ping_pong_done}); end
        checks++; if (ping_id !== 32'd0 || ping_time !== 32'd0 || pong_time !== 32'd0) begin errors++; $display("FAIL reset_regs got id=%0h pt=%0h qt=%0h exp 0", ping_id, ping_time, pong_time); end
        checks++; if (ping_pongs_good !== 64'd0 || pings_lost !== 64'd0 || pongs_lost !== 64'd0) begin errors++; $display("FAIL reset_counters got %0d %0d %0d exp 0", ping_pongs_good, pings_lost, pongs_lost); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_good_exchange();
        int cyc;
        soft_reset();
        delay = 32'd10; timeout = 32'd100; enable = 1'b1;
        wait_ping_start(50, cyc);
        checks++; if (cyc !== 12) begin errors++; $display("FAIL good_ping_start_latency got %0d exp 12", cyc); end
        checks++; if (ping_id !== 32'd1) begin errors++; $display("FAIL good_ping_id got %0d exp 1", ping_id); end
        pulse_ping_tx(64'd1000);
        checks++; if (ping_start !== 1'b0 || state !== 3'(WAIT_PING)) begin errors++; $display("FAIL good_wait_ping got start=%b st=%0d exp 0/%0d", ping_start, state, WAIT_PING); end
        pulse_ping_rx(32'd7, 64'd1100);
        checks++; if (pong_start !== 1'b0 || state !== 3'(WAIT_PING)) begin errors++; $display("FAIL good_bad_id_ignored got pong=%b st=%0d exp 0/%0d", pong_start, state, WAIT_PING); end
        pulse_ping_rx(32'd1, 64'd1250);
        checks++; if (pong_start !== 1'b1 || ping_time !== 32'd250) begin errors++; $display("FAIL good_ping_match got pong=%b pt=%0d exp 1/250", pong_start, ping_time); end
        step();
        checks++; if (pong_start !== 1'b0) begin errors++; $display("FAIL good_pong_start_width got %b exp 0", pong_start); end
        pulse_pong_tx(64'd1300);
        pulse_pong_rx(32'd1, 64'd1420);
        checks++; if (ping_pong_done !== 1'b1 || pong_time !== 32'd120 || ping_time !== 32'd250) begin errors++; $display("FAIL good_done got d=%b qt=%0d pt=%0d exp 1/120/250", ping_pong_done, pong_time, ping_time); end
        checks++; if (ping_pongs_good !== 64'd1 || pings_lost !== 64'd0 || pongs_lost !== 64'd0) begin errors++; $display("FAIL good_counters got %0d %0d %0d exp 1 0 0", ping_pongs_good, pings_lost, pongs_lost); end
        step();
        checks++; if (ping_pong_done !== 1'b0 || state !== 3'(DELAY)) begin errors++; $display("FAIL good_after_done got d=%b st=%0d exp 0/%0d", ping_pong_done, state, DELAY); end
    endtask

    task automatic test_ping_lost();
        int cyc;
        logic pong_seen;
        soft_reset();
        delay = 32'd10; timeout = 32'd100; enable = 1'b1;
        wait_ping_start(50, cyc);
        checks++; if (cyc !== 12) begin errors++; $display("FAIL plost_first_start got %0d exp 12", cyc); end
        pulse_ping_tx(64'd2000);
        wait_done(200, cyc, pong_seen);
        checks++; if (cyc !== 101) begin errors++; $display("FAIL plost_timeout_latency got %0d exp 101", cyc); end
        checks++; if (pong_seen !== 1'b0) begin errors++; $display("FAIL plost_no_pong got %b exp 0", pong_seen); end
        checks++; if (pings_lost !== 64'd1 || ping_pongs_good !== 64'd0 || pongs_lost !== 64'd0) begin errors++; $display("FAIL plost_counters got %0d %0d %0d exp 1 0 0", pings_lost, ping_pongs_good, pongs_lost); end
        checks++; if (ping_time !== TIME_LOST || pong_time !== TIME_LOST) begin errors++; $display("FAIL plost_times got %0h %0h exp ffffffff", ping_time, pong_time); end
        wait_ping_start(50, cyc);
        checks++; if (cyc !== 11 || ping_id !== 32'd2) begin errors++; $display("FAIL plost_next_ping got cyc=%0d id=%0d exp 11/2", cyc, ping_id); end
    endtask

    task automatic test_pong_lost_and_boundary();
        int cyc;
        logic pong_seen;
        logic done_seen;
        soft_reset();
        delay = 32'd0; timeout = 32'd5; enable = 1'b1;
        wait_ping_start(20, cyc);
        checks++; if (cyc !== 2) begin errors++; $display("FAIL zero_delay_start got %0d exp 2", cyc); end
        pulse_ping_tx(64'd100);
        pulse_ping_rx(32'd1, 64'd130);
        pulse_pong_tx(64'd500);
        pulse_pong_rx(32'd0, 64'd502);
        checks++; if (ping_pong_done !== 1'b0) begin errors++; $display("FAIL qlost_stale_id got %b exp 0", ping_pong_done); end
        wait_done(50, cyc, pong_seen);
        checks++; if (cyc !== 5) begin errors++; $display("FAIL qlost_timeout_latency got %0d exp 5", cyc); end
        checks++; if (pongs_lost !== 64'd1 || ping_pongs_good !== 64'd0 || pings_lost !== 64'd0) begin errors++; $display("FAIL qlost_counters got %0d %0d %0d exp 1 0 0", pongs_lost, ping_pongs_good, pings_lost); end
        checks++; if (pong_time !== TIME_LOST || ping_time !== 32'd30) begin errors++; $display("FAIL qlost_times got qt=%0h pt=%0d exp ffffffff/30", pong_time, ping_time); end
        // Second exchange: oversized ping delta saturates; pong lands exactly at timeout.
        wait_ping_start(20, cyc);
        checks++; if (cyc !== 1 || ping_id !== 32'd2) begin errors++; $display("FAIL edge_next_ping got cyc=%0d id=%0d exp 1/2", cyc, ping_id); end
        pulse_ping_tx(64'd0);
        pulse_ping_rx(32'd2, 64'h1_0000_0005);
        checks++; if (ping_time !== TIME_LOST) begin errors++; $display("FAIL edge_saturate got %0h exp ffffffff", ping_time); end
        pulse_pong_tx(64'h1_0000_0010);
        done_seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (ping_pong_done) done_seen = 1'b1;
        end
        checks++; if (done_seen !== 1'b0) begin errors++; $display("FAIL edge_early_done got %b exp 0", done_seen); end
        pulse_pong_rx(32'd2, 64'h1_0000_0017);
        checks++; if (ping_pong_done !== 1'b1 || pong_time !== 32'd7) begin errors++; $display("FAIL edge_match_at_timeout got d=%b qt=%0d exp 1/7", ping_pong_done, pong_time); end
        checks++; if (ping_pongs_good !== 64'd1 || pongs_lost !== 64'd1) begin errors++; $display("FAIL edge_counters got good=%0d qlost=%0d exp 1/1", ping_pongs_good, pongs_lost); end
    endtask

    task automatic test_enable_drop_and_srst();
        int cyc;
        logic done_seen;
        soft_reset();
        delay = 32'd2; timeout = 32'd50; enable = 1'b1;
        wait_ping_start(20, cyc);
        checks++; if (cyc !== 4) begin errors++; $display("FAIL drop_start got %0d exp 4", cyc); end
        pulse_ping_tx(64'd10);
        enable = 1'b0;
        step(); step(); step();
        checks++; if (state !== 3'(WAIT_PING)) begin errors++; $display("FAIL drop_no_abort got %0d exp %0d", state, WAIT_PING); end
        pulse_ping_rx(32'd1, 64'd20);
        pulse_pong_tx(64'd30);
        pulse_pong_rx(32'd1, 64'd45);
        checks++; if (ping_pong_done !== 1'b1 || ping_pongs_good !== 64'd1 || pong_time !== 32'd15) begin errors++; $display("FAIL drop_complete got d=%b good=%0d qt=%0d exp 1/1/15", ping_pong_done, ping_pongs_good, pong_time); end
        step();
        checks++; if (state !== 3'(IDLE)) begin errors++; $display("FAIL drop_to_idle got %0d exp %0d", state, IDLE); end
        enable = 1'b1;
        wait_ping_start(20, cyc);
        checks++; if (cyc !== 4 || ping_id !== 32'd2) begin errors++; $display("FAIL srst_second_ping got cyc=%0d id=%0d exp 4/2", cyc, ping_id); end
        pulse_ping_tx(64'd100);
        pulse_ping_rx(32'd2, 64'd110);
        pulse_pong_tx(64'd120);
        checks++; if (state !== 3'(WAIT_PONG)) begin errors++; $display("FAIL srst_in_wait_pong got %0d exp %0d", state, WAIT_PONG); end
        soft_reset();
        checks++; if (state !== 3'(IDLE) || ping_pong_done !== 1'b0 || ping_id !== 32'd0) begin errors++; $display("FAIL srst_state got st=%0d d=%b id=%0d exp %0d/0/0", state, ping_pong_done, ping_id, IDLE); end
        checks++; if (ping_time !== 32'd0 || pong_time !== 32'd0 || ping_pongs_good !== 64'd0 || pings_lost !== 64'd0 || pongs_lost !== 64'd0) begin errors++; $display("FAIL srst_results got %0h %0h %0d %0d %0d exp 0", ping_time, pong_time, ping_pongs_good, pings_lost, pongs_lost); end
        done_seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (ping_pong_done || ping_start || pong_start) done_seen = 1'b1;
        end
        checks++; if (done_seen !== 1'b0) begin errors++; $display("FAIL srst_quiet got %b exp 0", done_seen); end
    endtask

    initial begin
        test_reset();
        test_good_exchange();
        test_ping_lost();
        test_pong_lost_and_boundary();
        test_enable_drop_and_srst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/eth_measurer_core.md
ETH_MEASURER_CORE -- requirements
Module: eth_measurer_core

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, named clk and rst_n: clk  in  1  rising-edge clock for all state; rst_n  in  1  asynchronous active-low reset.
REQ-002 Configuration ports SHALL be: enable  in  1  start/continue exchanges; srst  in  1  synchronous soft reset; delay  in  32  idle cycles between exchanges; timeout  in  32  max cycles waiting for each leg; current_time  in  64  free-running timestamp.
REQ-003 Ping-side ports SHALL be: ping_start  out  1  one-cycle send request to main-port generator; ping_id  out  32  sequence id of current ping; ping_tx_done  in  1  ping frame fully transmitted; pong_rx_valid  in  1  pong frame received on main port; pong_rx_id  in  32  id carried by that pong.
REQ-004 Loop-side ports SHALL be: pong_start  out  1  one-cycle send request to loop-port generator; ping_rx_valid  in  1  ping frame received on loop port; ping_rx_id  in  32  id carried by that ping; pong_tx_done  in  1  pong frame fully transmitted.
REQ-005 Result ports SHALL be: ping_pong_done  out  1  one-cycle exchange-complete strobe; ping_time  out  32; pong_time  out  32; ping_pongs_good  out  64; pings_lost  out  64; pongs_lost  out  64.

Function
REQ-006 FSM states SHALL be IDLE, DELAY, PING_TX, WAIT_PING, PONG_TX, WAIT_PONG; one 32-bit cycle timer shared by DELAY and WAIT states.
REQ-007 IDLE: enable=1 -> DELAY, timer<=0.
REQ-008 DELAY: timer increments each cycle; enable=0 -> IDLE immediately; timer>=delay -> PING_TX with ping_start=1 for that one cycle and ping_id<=ping_id+1 (wraps); delay=0 gives ping_start on the second DELAY cycle... exactly the first cycle where timer>=delay, i.e. DELAY lasts delay+1 cycles.
REQ-009 PING_TX: on ping_tx_done capture t_tx<=current_time, timer<=0 -> WAIT_PING; no timeout in this state.
REQ-010 WAIT_PING: ping_rx_valid with ping_rx_id==ping_id -> ping_time<=current_time-t_tx (low 32 bits, saturate to 0xFFFFFFFF if difference >=2^32), pong_start=1 one cycle -> PONG_TX; non-matching ids ignored.
REQ-011 WAIT_PING: else if timer>=timeout -> pings_lost+=1, ping_time<=0xFFFFFFFF, pong_time<=0xFFFFFFFF, ping_pong_done=1 -> next state per REQ-015; match takes priority over timeout in the same cycle.
REQ-012 PONG_TX: on pong_tx_done capture t_tx<=current_time, timer<=0 -> WAIT_PONG.
REQ-013 WAIT_PONG: pong_rx_valid with pong_rx_id==ping_id -> pong_time<=current_time-t_tx (saturating as REQ-010), ping_pongs_good+=1, ping_pong_done=1; else timer>=timeout -> pongs_lost+=1, pong_time<=0xFFFFFFFF, ping_pong_done=1.
REQ-014 On the ping_pong_done cycle, ping_time, pong_time and all three counters SHALL already hold the updated values (registered together).
REQ-015 After done: enable=1 -> DELAY with timer<=0; enable=0 -> IDLE.
REQ-016 enable deassertion outside IDLE/DELAY SHALL NOT abort the exchange; it completes via match or timeout.
REQ-017 64-bit counters SHALL wrap modulo 2^64; ping_id wraps modulo 2^32.
REQ-018 timer SHALL saturate at 0xFFFFFFFF; timeout=0 means loss on the first WAIT cycle unless a match arrives that cycle.
REQ-019 ping_start, pong_start, ping_pong_done SHALL each be high for exactly one cycle per event.

Reset
REQ-020 rst_n=0 (asynchronous) or srst=1 (synchronous) SHALL force: state IDLE, timer 0, t_tx 0, ping_id 0, all strobes 0, ping_time 0, pong_time 0, all counters 0.
REQ-021 Reset mid-exchange SHALL discard it with no ping_pong_done and no counter increment.

Structure
REQ-022 State enum SHALL live in shared package eth_measurer_pkg together with constant TIME_LOST=32'hFFFFFFFF.
REQ-023 No sub-module; single FSM plus datapath registers.

Verification
REQ-024 delay=10, timeout=100, enable=1; ping_tx_done at t=1000, matching ping_rx at t=1250, pong_tx_done at t=1300, matching pong_rx at t=1420 -> ping_time=250, pong_time=120, ping_pongs_good=1, one done strobe.
REQ-025 No ping_rx for 100 cycles after ping_tx_done, timeout=100 -> pings_lost=1, ping_time=pong_time=0xFFFFFFFF, no pong_start, next ping_start after 11 DELAY cycles with ping_id=2.
REQ-026 Pong with ping_id-1 then timeout -> pongs_lost=1, ping_pongs_good unchanged, pong_time=0xFFFFFFFF.
REQ-027 Match and timer==timeout in same WAIT_PONG cycle -> counted good, not lost.
REQ-028 enable=0 in WAIT_PING then match -> exchange completes, FSM goes IDLE; srst pulse in WAIT_PONG -> all outputs 0, no done strobe.
